branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side producer of the `predicted_branch_taken` / `predicted_branch_target` pair that the next-PC mux consumes.
- Built as a direct-mapped branch target buffer (BTB), with a 2-bit saturating counter per entry.
- Looked up combinationally with the current fetch PC.
- Trained by the execute-stage branch resolution: actual outcome, actual target, and branch PC.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entry count; power of two, ≥2.
- INDEX_BITS, $clog2(ENTRIES), derived; index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- fetch_pc  input  XLEN  PC being fetched this cycle.
- predicted_branch_taken  output  1  predict taken for fetch_pc.
- predicted_branch_target  output  XLEN  predicted target for fetch_pc.
- btb_hit  output  1  fetch_pc matches a valid entry.
- update_valid  input  1  a branch/jump resolved this cycle.
- update_pc  input  XLEN  PC of the resolved branch.
- update_taken  input  1  resolved direction.
- update_target  input  XLEN  resolved taken target.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; on a reset cycle no update is applied.
- Address split:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[XLEN-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry state: valid (1), tag, target (XLEN), ctr (2-bit).
- Reset: all valid=0 and all ctr=2'b01; tag and target are don't-care. Outputs after reset: btb_hit=0, predicted_branch_taken=0, predicted_branch_target=0.
- Lookup is purely combinational, zero latency, same cycle as fetch_pc:
  - btb_hit = valid[idx] && tag[idx]==tag(fetch_pc).
  - predicted_branch_taken = btb_hit && ctr[idx][1].
  - predicted_branch_target = target[idx] when btb_hit, else 0.
- Update applies at the posedge when update_valid=1 and reset=0:
  - Hit (valid and tag match), update_taken=1: ctr saturating increment (max 2'b11); target ← update_target.
  - Hit, update_taken=0: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, update_taken=1: allocate/replace. valid←1, tag←tag(update_pc), target←update_target, ctr←2'b10 (weakly taken).
  - Miss, update_taken=0: no state change; not-taken branches are never allocated.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = ctr[1].
- Simultaneous lookup and update to the same index: lookup returns pre-update state; no write-through bypass. The new state is visible the next cycle.
- Aliasing: a different tag at the same index replaces the entry only via a taken miss.
- Reset mid-operation: reset dominates update_valid in the same cycle.
- Single write port: at most one update per cycle.

Test Plan:
- Reset with ENTRIES=16, then fetch_pc=0x100 → btb_hit=0, taken=0, target=0.
- Update pc=0x100, taken=1, target=0x200; next cycle fetch_pc=0x100 → hit=1, taken=1, target=0x200 (ctr=10).
- Same branch:
  - Two not-taken updates → ctr 10→01→00; fetch → hit=1, taken=0.
  - Then 5 taken updates → ctr saturates at 11; one NT update → ctr 10, still predicts taken.
- Alias: entry 0x100 present; update pc=0x140 (same index 0, different tag), taken=0 → 0x100 still hits. Then taken=1, target=0x300 → fetch 0x100 misses; fetch 0x140 hits with target 0x300.
- Same-cycle collision: fetch_pc=0x100 while updating 0x100 taken=1, target=0x400 → that cycle's target is the old value; next cycle it is 0x400.
- Reset asserted together with update_valid=1 → no allocation; all subsequent lookups miss.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Combinational lookup on fetch_pc, single-port training from execute.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    localparam int INDEX_BITS = $clog2(ENTRIES),
    localparam int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predicted_branch_taken,
    output logic [XLEN-1:0] predicted_branch_target,
    output logic            btb_hit,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target
);

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]       target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;

    logic                  we;
    logic [TAG_BITS-1:0]   tag_d;
    logic [XLEN-1:0]       target_d;
    logic [1:0]            ctr_d;

    logic                  unused_lsbs;

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[XLEN-1:INDEX_BITS+2];
    assign u_idx = update_pc[INDEX_BITS+1:2];
    assign u_tag = update_pc[XLEN-1:INDEX_BITS+2];

    // Instructions are word aligned; the low PC bits carry no information.
    assign unused_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

    // Lookup: reads pre-update state, no bypass from the write port.
    always_comb begin
        btb_hit                 = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predicted_branch_taken  = btb_hit && ctr_q[f_idx][1];
        predicted_branch_target = btb_hit ? target_q[f_idx] : '0;
    end

    // Training: compute the new contents of the indexed entry.
    always_comb begin
        logic u_hit;
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        we       = 1'b0;
        tag_d    = tag_q[u_idx];
        target_d = target_q[u_idx];
        ctr_d    = ctr_q[u_idx];
        if (update_valid) begin
            if (u_hit) begin
                we = 1'b1;
                if (update_taken) begin
                    target_d = update_target;
                    if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
                end else begin
                    if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Only taken branches earn a slot; start weakly taken.
                we       = 1'b1;
                tag_d    = u_tag;
                target_d = update_target;
                ctr_d    = 2'b10;
            end
        end
    end

    // Entry storage; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (we) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= tag_d;
            target_q[u_idx] <= target_d;
            ctr_q[u_idx]    <= ctr_d;
        end
    end

endmodule
